// File: rtl/cordic_seq_ctrl.sv
// rtl/cordic_seq_ctrl.sv - iterative CORDIC job sequencer; optional CORDIC_HYP_REPEAT_EN enables hyperbolic repeat iterations
module cordic_seq_ctrl #(
    parameter int WIDTH  = 32,
    parameter int ITER_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [WIDTH-1:0]  x_in,
    input  logic [WIDTH-1:0]  y_in,
    input  logic [WIDTH-1:0]  z_in,
    input  logic              cfg_mode,
    input  logic              cfg_sys,
    input  logic [ITER_W-1:0] cfg_iters,
    input  logic              cfg_ov_stop_en,
    input  logic              cfg_z_ov_stop_en,
    input  logic              cfg_err_irq_en,
    input  logic              cfg_rslt_irq_en,
    input  logic              stop,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  x_out,
    output logic [WIDTH-1:0]  y_out,
    output logic [WIDTH-1:0]  z_out,
    output logic              busy,
    output logic              inp_err,
    output logic              ov_err,
    output logic              x_ov,
    output logic              y_ov,
    output logic              z_ov,
    output logic [ITER_W-1:0] iter_elapsed,
    output logic [ITER_W-1:0] ov_iter,
    output logic              irq,
    output logic [WIDTH-1:0]  dp_x,
    output logic [WIDTH-1:0]  dp_y,
    output logic [WIDTH-1:0]  dp_z,
    output logic [ITER_W-1:0] dp_shift,
    output logic              dp_dir,
    output logic              dp_sys,
    input  logic [WIDTH-1:0]  dp_x_res,
    input  logic [WIDTH-1:0]  dp_y_res,
    input  logic [WIDTH-1:0]  dp_z_res,
    input  logic              dp_x_ov,
    input  logic              dp_y_ov,
    input  logic              dp_z_ov,
    output logic [ITER_W-1:0] lut_offset,
    output logic              lut_sys,
    input  logic [WIDTH-1:0]  lut_angle,
    output logic [WIDTH-1:0]  dp_angle
);

    // Shift saturates at the word width, or at the counter range if that is narrower
    localparam int SHIFT_MAX_I = ((WIDTH - 1) < ((1 << ITER_W) - 1)) ? (WIDTH - 1) : ((1 << ITER_W) - 1);
    localparam logic [ITER_W-1:0] SHIFT_MAX = ITER_W'(SHIFT_MAX_I);
    // 90 degrees in turn-fraction units
    localparam logic [WIDTH-1:0]  QUARTER   = {2'b01, {(WIDTH-2){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        ITER = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Job configuration captured at acceptance
    logic              mode_r;
    logic              sys_r;
    logic [ITER_W-1:0] iters_r;
    logic              ov_stop_en_r;
    logic              z_ov_stop_en_r;
    logic              err_irq_en_r;
    logic              rslt_irq_en_r;

    logic [ITER_W-1:0] shift;
    logic [ITER_W-1:0] shift_inc;
    logic [ITER_W-1:0] shift_step;
    logic [ITER_W-1:0] iter_next;
    logic              ov_stop_hit;
    logic              irq_pend;

    logic              accept;
    logic              circ_fix;
    logic              hyp_bad;
    logic [WIDTH:0]    x_ext;
    logic [WIDTH:0]    y_ext;
    logic [WIDTH:0]    y_abs;
    logic              ov_stop_now;
    logic              iter_last;

`ifdef CORDIC_HYP_REPEAT_EN
    logic [ITER_W+1:0] next_rep;
    logic              rep_done;
    logic              rep_hit;
`endif

    assign accept      = start_valid && start_ready;
    assign start_ready = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);
    assign res_valid   = (state == DONE);
    assign irq         = res_valid && irq_pend;
    assign ov_err      = x_ov | y_ov | z_ov;

    assign dp_x       = x_out;
    assign dp_y       = y_out;
    assign dp_z       = z_out;
    assign dp_shift   = shift;
    assign lut_offset = shift;
    assign dp_dir     = mode_r;
    assign dp_sys     = sys_r;
    assign lut_sys    = sys_r;
    assign dp_angle   = lut_angle;

    assign iter_next = iter_elapsed + ITER_W'(1);
    assign shift_inc = (shift == SHIFT_MAX) ? shift : shift + ITER_W'(1);

    // Range reduction and hyperbolic input validity, evaluated on the latched operands
    always_comb begin
        x_ext    = {x_out[WIDTH-1], x_out};
        y_ext    = {y_out[WIDTH-1], y_out};
        y_abs    = y_ext[WIDTH] ? (~y_ext + 1'b1) : y_ext;
        circ_fix = sys_r && ((mode_r && (z_out > QUARTER)) || (!mode_r && x_out[WIDTH-1]));
        hyp_bad  = !sys_r && (x_out[WIDTH-1] || ($signed(y_abs) > $signed(x_ext)));
    end

    // Exit conditions judged on the iteration being committed this cycle
    always_comb begin
        ov_stop_now = (ov_stop_en_r && (dp_x_ov || dp_y_ov)) ||
                      (ov_stop_en_r && z_ov_stop_en_r && dp_z_ov);
        iter_last   = (iter_next == iters_r) || stop || ov_stop_now;
    end

    // Next shift value; hyperbolic runs may hold a shift for one repeat iteration
    always_comb begin
        shift_step = shift_inc;
`ifdef CORDIC_HYP_REPEAT_EN
        rep_hit = !sys_r && ({2'b00, shift} == next_rep);
        if (rep_hit && !rep_done) begin
            shift_step = shift;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = PRE;
                end
            end
            PRE: begin
                if (hyp_bad || (iters_r == '0)) begin
                    state_nxt = POST;
                end else begin
                    state_nxt = ITER;
                end
            end
            ITER: begin
                if (iter_last) begin
                    state_nxt = POST;
                end
            end
            POST: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Job configuration latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r         <= 1'b0;
            sys_r          <= 1'b0;
            iters_r        <= '0;
            ov_stop_en_r   <= 1'b0;
            z_ov_stop_en_r <= 1'b0;
            err_irq_en_r   <= 1'b0;
            rslt_irq_en_r  <= 1'b0;
        end else if (accept) begin
            mode_r         <= cfg_mode;
            sys_r          <= cfg_sys;
            iters_r        <= cfg_iters;
            ov_stop_en_r   <= cfg_ov_stop_en;
            z_ov_stop_en_r <= cfg_z_ov_stop_en;
            err_irq_en_r   <= cfg_err_irq_en;
            rslt_irq_en_r  <= cfg_rslt_irq_en;
        end
    end

    // Working registers: load, quadrant correction, per-iteration commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
        end else if (accept) begin
            x_out <= x_in;
            y_out <= y_in;
            z_out <= z_in;
        end else if (state == PRE) begin
            if (circ_fix) begin
                x_out <= -x_out;
                y_out <= -y_out;
                z_out <= {~z_out[WIDTH-1], z_out[WIDTH-2:0]};
            end
        end else if (state == ITER) begin
            x_out <= dp_x_res;
            y_out <= dp_y_res;
            z_out <= dp_z_res;
        end
    end

    // Status flags, counters and pending interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inp_err      <= 1'b0;
            x_ov         <= 1'b0;
            y_ov         <= 1'b0;
            z_ov         <= 1'b0;
            iter_elapsed <= '0;
            ov_iter      <= '0;
            ov_stop_hit  <= 1'b0;
            irq_pend     <= 1'b0;
        end else if (accept) begin
            inp_err      <= 1'b0;
            x_ov         <= 1'b0;
            y_ov         <= 1'b0;
            z_ov         <= 1'b0;
            iter_elapsed <= '0;
            ov_iter      <= '0;
            ov_stop_hit  <= 1'b0;
            irq_pend     <= 1'b0;
        end else if (state == PRE) begin
            inp_err <= hyp_bad;
        end else if (state == ITER) begin
            iter_elapsed <= iter_next;
            x_ov         <= x_ov | dp_x_ov;
            y_ov         <= y_ov | dp_y_ov;
            z_ov         <= z_ov | dp_z_ov;
            // ov_iter freezes on the first iteration that raised any overflow
            if (!ov_err) begin
                ov_iter <= iter_next;
            end
            if (ov_stop_now) begin
                ov_stop_hit <= 1'b1;
            end
        end else if (state == POST) begin
            irq_pend <= rslt_irq_en_r || (err_irq_en_r && (inp_err || ov_stop_hit));
        end
    end

    // Shift counter: circular starts at 0, hyperbolic at 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift <= '0;
        end else if (accept) begin
            shift <= '0;
        end else if (state == PRE) begin
            shift <= sys_r ? '0 : ITER_W'(1);
        end else if (state == ITER) begin
            shift <= shift_step;
        end
    end

`ifdef CORDIC_HYP_REPEAT_EN
    // Repeat bookkeeping: each repeat shift 4, 13, 40, ... is used twice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_rep <= '0;
            rep_done <= 1'b0;
        end else if (accept || (state == PRE)) begin
            next_rep <= (ITER_W+2)'(4);
            rep_done <= 1'b0;
        end else if ((state == ITER) && rep_hit) begin
            if (!rep_done) begin
                rep_done <= 1'b1;
            end else begin
                rep_done <= 1'b0;
                next_rep <= next_rep + (next_rep << 1) + (ITER_W+2)'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// tb/tb_cordic_seq_ctrl.sv - scoreboard bench for cordic_seq_ctrl with behavioural datapath and angle LUT
`timescale 1ns/1ps
module tb_cordic_seq_ctrl;
    localparam int WIDTH  = 32;
    localparam int ITER_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_valid;
    logic              start_ready;
    logic [WIDTH-1:0]  x_in, y_in, z_in;
    logic              cfg_mode, cfg_sys;
    logic [ITER_W-1:0] cfg_iters;
    logic              cfg_ov_stop_en, cfg_z_ov_stop_en, cfg_err_irq_en, cfg_rslt_irq_en;
    logic              stop;
    logic              res_valid, res_ready;
    logic [WIDTH-1:0]  x_out, y_out, z_out;
    logic              busy, inp_err, ov_err, x_ov, y_ov, z_ov;
    logic [ITER_W-1:0] iter_elapsed, ov_iter;
    logic              irq;
    logic [WIDTH-1:0]  dp_x, dp_y, dp_z;
    logic [ITER_W-1:0] dp_shift;
    logic              dp_dir, dp_sys;
    logic [WIDTH-1:0]  dp_x_res, dp_y_res, dp_z_res;
    logic              dp_x_ov, dp_y_ov, dp_z_ov;
    logic [ITER_W-1:0] lut_offset;
    logic              lut_sys;
    logic [WIDTH-1:0]  lut_angle, dp_angle;

    cordic_seq_ctrl #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .cfg_mode(cfg_mode), .cfg_sys(cfg_sys), .cfg_iters(cfg_iters),
        .cfg_ov_stop_en(cfg_ov_stop_en), .cfg_z_ov_stop_en(cfg_z_ov_stop_en),
        .cfg_err_irq_en(cfg_err_irq_en), .cfg_rslt_irq_en(cfg_rslt_irq_en),
        .stop(stop), .res_valid(res_valid), .res_ready(res_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .busy(busy), .inp_err(inp_err), .ov_err(ov_err),
        .x_ov(x_ov), .y_ov(y_ov), .z_ov(z_ov),
        .iter_elapsed(iter_elapsed), .ov_iter(ov_iter), .irq(irq),
        .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z), .dp_shift(dp_shift),
        .dp_dir(dp_dir), .dp_sys(dp_sys),
        .dp_x_res(dp_x_res), .dp_y_res(dp_y_res), .dp_z_res(dp_z_res),
        .dp_x_ov(dp_x_ov), .dp_y_ov(dp_y_ov), .dp_z_ov(dp_z_ov),
        .lut_offset(lut_offset), .lut_sys(lut_sys),
        .lut_angle(lut_angle), .dp_angle(dp_angle)
    );

    always #5 clk = ~clk;

    // Angle table: atan(2^-i) as a fraction of a full turn, 2^32 = 360 degrees
    logic [WIDTH-1:0] lut_tab [32];
    assign lut_angle = lut_tab[lut_offset];

    // Datapath model; stub mode passes operands through and injects dp_x_ov on one iteration
    logic stub;
    int   ovx_at;
    logic d_pos;
    logic signed [WIDTH:0] xa, ya, xsh, ysh, xn, yn;
    logic [WIDTH-1:0] zn;
    always_comb begin
        d_pos = dp_dir ? ~dp_z[WIDTH-1] : dp_y[WIDTH-1];
        xa    = $signed({dp_x[WIDTH-1], dp_x});
        ya    = $signed({dp_y[WIDTH-1], dp_y});
        xsh   = xa >>> dp_shift;
        ysh   = ya >>> dp_shift;
        if (dp_sys) xn = d_pos ? xa - ysh : xa + ysh;
        else        xn = d_pos ? xa + ysh : xa - ysh;
        yn    = d_pos ? ya + xsh : ya - xsh;
        zn    = d_pos ? dp_z - dp_angle : dp_z + dp_angle;
        dp_z_ov = 1'b0;
        if (stub) begin
            dp_x_res = dp_x;
            dp_y_res = dp_y;
            dp_z_res = dp_z;
            dp_x_ov  = (ovx_at == int'(iter_elapsed));
            dp_y_ov  = 1'b0;
        end else begin
            dp_x_res = xn[WIDTH-1:0];
            dp_y_res = yn[WIDTH-1:0];
            dp_z_res = zn;
            dp_x_ov  = xn[WIDTH] ^ xn[WIDTH-1];
            dp_y_ov  = yn[WIDTH] ^ yn[WIDTH-1];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic near(input logic [31:0] a, input logic [31:0] b, input int tol);
        logic signed [31:0] d;
        d = $signed(a - b);
        return (d <= tol) && (d >= -tol);
    endfunction

    typedef struct {
        string       name;
        int          lat;
        int          iters;
        int          ov_iter;
        logic        inp_err;
        logic        x_ov;
        logic        irq;
        logic        chk_xyz;
        logic [31:0] xe;
        logic [31:0] ye;
    } exp_t;

    exp_t sb[$];
    logic [ITER_W-1:0] offs[$];

    function automatic exp_t mk(input string n, input int lat, input int it, input int ovi,
                                input logic ie, input logic xo, input logic ir,
                                input logic cx, input logic [31:0] xe, input logic [31:0] ye);
        exp_t e;
        e.name = n; e.lat = lat; e.iters = it; e.ov_iter = ovi;
        e.inp_err = ie; e.x_ov = xo; e.irq = ir; e.chk_xyz = cx; e.xe = xe; e.ye = ye;
        return e;
    endfunction

    task automatic drive_start(input logic [31:0] xi, input logic [31:0] yi, input logic [31:0] zi,
                               input logic mode, input logic sys, input int iters,
                               input logic ovs, input logic eirq, input logic rirq);
        @(negedge clk);
        x_in = xi; y_in = yi; z_in = zi;
        cfg_mode = mode; cfg_sys = sys; cfg_iters = iters[ITER_W-1:0];
        cfg_ov_stop_en = ovs; cfg_z_ov_stop_en = 1'b0;
        cfg_err_irq_en = eirq; cfg_rslt_irq_en = rirq;
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    task automatic run_job(input logic [31:0] xi, input logic [31:0] yi, input logic [31:0] zi,
                           input logic mode, input logic sys, input int iters,
                           input logic ovs, input logic eirq, input logic rirq,
                           input int stop_at, input int hold, input exp_t e);
        int   lat;
        logic seen;
        logic stop_done;
        logic stable;
        int   prev_it;
        logic [ITER_W-1:0] prev_off;
        logic [WIDTH-1:0]  hx;
        exp_t ex;
        drive_start(xi, yi, zi, mode, sys, iters, ovs, eirq, rirq);
        sb.push_back(e);
        offs.delete();
        lat = 0; seen = 1'b0; stop_done = 1'b0; prev_it = 0; prev_off = '0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            stop = 1'b0;
            if (int'(iter_elapsed) != prev_it) offs.push_back(prev_off);
            prev_it  = int'(iter_elapsed);
            prev_off = lut_offset;
            if (stop_at > 0 && !stop_done && int'(iter_elapsed) == stop_at - 1) begin
                stop = 1'b1;
                stop_done = 1'b1;
            end
            if (res_valid) seen = 1'b1;
        end
        stop = 1'b0;
        if (sb.size() == 0) begin
            check({e.name, "/sb_empty"}, 0, 1);
            return;
        end
        ex = sb.pop_front();
        check({ex.name, "/res_valid"}, seen, 1);
        check({ex.name, "/latency"}, lat, ex.lat);
        check({ex.name, "/iter_elapsed"}, iter_elapsed, ex.iters);
        check({ex.name, "/ov_iter"}, ov_iter, ex.ov_iter);
        check({ex.name, "/inp_err"}, inp_err, ex.inp_err);
        check({ex.name, "/x_ov"}, x_ov, ex.x_ov);
        check({ex.name, "/ov_err"}, ov_err, ex.x_ov);
        check({ex.name, "/irq"}, irq, ex.irq);
        if (ex.chk_xyz) begin
            check({ex.name, "/x_near"}, near(x_out, ex.xe, 64), 1);
            check({ex.name, "/y_near"}, near(y_out, ex.ye, 64), 1);
            check({ex.name, "/z_near"}, near(z_out, 32'h0, 64), 1);
        end
        if (hold > 0) begin
            hx = x_out;
            stable = 1'b1;
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                if (!res_valid || (x_out !== hx) || start_ready || (irq !== ex.irq)) stable = 1'b0;
            end
            check({ex.name, "/hold_stable"}, stable, 1);
        end
        // Release the result with a concurrent start that must be refused
        @(negedge clk);
        res_ready = 1'b1;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        start_valid = 1'b0;
        check({ex.name, "/irq_drop"}, irq, 0);
        check({ex.name, "/no_accept"}, busy, 0);
    endtask

    logic [ITER_W-1:0] exp_offs [6];

    initial begin
        real p;
        p = 1.0;
        for (int i = 0; i < 32; i++) begin
            lut_tab[i] = 32'($rtoi($atan(p) / (2.0 * 3.14159265358979) * 4294967296.0 + 0.5));
            p = p / 2.0;
        end
`ifdef CORDIC_HYP_REPEAT_EN
        exp_offs = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 5'd5};
`else
        exp_offs = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
`endif
        rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; stop = 1'b0;
        x_in = '0; y_in = '0; z_in = '0; cfg_mode = 1'b0; cfg_sys = 1'b0; cfg_iters = '0;
        cfg_ov_stop_en = 1'b0; cfg_z_ov_stop_en = 1'b0; cfg_err_irq_en = 1'b0; cfg_rslt_irq_en = 1'b0;
        stub = 1'b0; ovx_at = -1;

        repeat (3) @(negedge clk);
        check("rst/start_ready", start_ready, 0);
        check("rst/busy", busy, 0);
        check("rst/res_valid", res_valid, 0);
        check("rst/x_out", x_out, 0);
        rst = 1'b0;
        #1 check("rst/ready_after", start_ready, 1);

        // Circular rotation by 45 degrees with gain-compensated x
        run_job(32'h4DBA76D4, 32'h0, 32'h20000000, 1'b1, 1'b1, 31, 1'b0, 1'b0, 1'b1, 0, 0,
                mk("circ45", 33, 31, 31, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5A82799A, 32'h5A82799A));
        // 135 degrees exercises the quadrant correction
        run_job(32'h4DBA76D4, 32'h0, 32'h60000000, 1'b1, 1'b1, 31, 1'b0, 1'b0, 1'b0, 0, 0,
                mk("circ135", 33, 31, 31, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA57D8666, 32'h5A82799A));

        // Hyperbolic shift sequence with a stubbed datapath
        stub = 1'b1;
        run_job(32'h10000000, 32'h0, 32'h0, 1'b1, 1'b0, 6, 1'b0, 1'b0, 1'b0, 0, 0,
                mk("hyp_seq", 8, 6, 6, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
        check("hyp_seq/n_offs", offs.size(), 6);
        for (int i = 0; i < 6 && i < offs.size(); i++)
            check($sformatf("hyp_seq/off%0d", i), offs[i], exp_offs[i]);

        // Hyperbolic input error
        run_job(32'h10000000, 32'h20000000, 32'h0, 1'b1, 1'b0, 6, 1'b0, 1'b1, 1'b0, 0, 0,
                mk("hyp_err", 2, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0));

        // Overflow on the 3rd iteration, with and without stop-on-overflow
        ovx_at = 2;
        run_job(32'h1000, 32'h0, 32'h0, 1'b1, 1'b1, 20, 1'b1, 1'b1, 1'b0, 0, 0,
                mk("ov_stop", 5, 3, 3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
        run_job(32'h1000, 32'h0, 32'h0, 1'b1, 1'b1, 20, 1'b0, 1'b1, 1'b0, 0, 0,
                mk("ov_run", 22, 20, 3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0));
        ovx_at = -1;

        // Zero iterations
        run_job(32'h1000, 32'h0, 32'h0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 0, 0,
                mk("iters0", 2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0));

        // Abort during the 5th iteration, result then held for 10 cycles
        run_job(32'h1000, 32'h0, 32'h0, 1'b1, 1'b1, 20, 1'b0, 1'b0, 1'b1, 5, 10,
                mk("stop5", 7, 5, 5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0));

        // Reset in the middle of a job
        drive_start(32'h4DBA76D4, 32'h0, 32'h0, 1'b1, 1'b1, 20, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid/busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst/busy", busy, 0);
        check("mid_rst/x_out", x_out, 0);
        check("mid_rst/iter_elapsed", iter_elapsed, 0);
        check("mid_rst/lut_offset", lut_offset, 0);
        check("mid_rst/start_ready", start_ready, 0);
        check("mid_rst/irq", irq, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("mid_rst/ready_after", start_ready, 1);
        stub = 1'b0;
        run_job(32'h4DBA76D4, 32'h0, 32'h20000000, 1'b1, 1'b1, 31, 1'b0, 1'b0, 1'b1, 0, 0,
                mk("after_rst", 33, 31, 31, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5A82799A, 32'h5A82799A));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
